raw_data_decoder: RTL and testbench

//  Receive-side counterpart of the raw-data lane encoder. Pops encoded lane words (lane 0..3,

---
 rtl/raw_data_decoder.sv | 146 ++++++++++++++
 tb/tb_raw_data_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/raw_data_decoder.sv
// Receive-side lane reassembler: pops four encoded lane words (lane 0..3) that share
// one index tag, packs them into a single raw word and pushes it to the raw FIFO.
// Out-of-order lanes or index changes are counted as errors; the partial word is
// dropped and collection restarts on the next lane-0 word.
module raw_data_decoder #(
    parameter int LANE_W = 8,
    parameter int IDX_W  = 8,
    parameter int ERR_W  = 8,
    parameter int DATA_W = 4 * LANE_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enc_fifo_empty,
    output logic              enc_fifo_pop,
    input  logic [LANE_W-1:0] enc_data_in,
    input  logic [1:0]        enc_lane_in,
    input  logic [IDX_W-1:0]  enc_index_in,
    input  logic [3:0]        enc_wstrb_in,
    input  logic              raw_fifo_full,
    output logic              raw_fifo_push,
    output logic              raw_fifo_clr,
    output logic [DATA_W-1:0] raw_data_out,
    output logic [IDX_W-1:0]  raw_index_out,
    output logic [3:0]        raw_wstrb_out,
    output logic              lane_err,
    output logic [ERR_W-1:0]  err_count
);

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        COLLECT_0 = 3'd1,
        COLLECT_1 = 3'd2,
        COLLECT_2 = 3'd3,
        COLLECT_3 = 3'd4,
        PUSH      = 3'd5
    } state_t;

    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    state_t     state;
    state_t     next_state;
    logic [1:0] cur_lane;
    logic       latch_first;
    logic       latch_next;
    logic       seq_err;

    // State register; reset parks the machine in INIT so the raw FIFO gets cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, FIFO handshakes and lane-latch decisions.
    always_comb begin
        next_state    = state;
        cur_lane      = 2'd0;
        enc_fifo_pop  = 1'b0;
        raw_fifo_push = 1'b0;
        latch_first   = 1'b0;
        latch_next    = 1'b0;
        seq_err       = 1'b0;
        case (state)
            INIT: begin
                next_state = COLLECT_0;
            end
            COLLECT_0, COLLECT_1, COLLECT_2, COLLECT_3: begin
                case (state)
                    COLLECT_1: cur_lane = 2'd1;
                    COLLECT_2: cur_lane = 2'd2;
                    COLLECT_3: cur_lane = 2'd3;
                    default:   cur_lane = 2'd0;
                endcase
                if (!enc_fifo_empty) begin
                    enc_fifo_pop = 1'b1;
                    if (cur_lane == 2'd0 && enc_lane_in == 2'd0) begin
                        latch_first = 1'b1;
                        next_state  = COLLECT_1;
                    end else if (cur_lane != 2'd0 && enc_lane_in == cur_lane &&
                                 enc_index_in == raw_index_out) begin
                        latch_next = 1'b1;
                        case (cur_lane)
                            2'd1:    next_state = COLLECT_2;
                            2'd2:    next_state = COLLECT_3;
                            default: next_state = PUSH;
                        endcase
                    end else begin
                        seq_err = 1'b1;
                        if (enc_lane_in == 2'd0) begin
                            latch_first = 1'b1;
                            next_state  = COLLECT_1;
                        end else begin
                            next_state = COLLECT_0;
                        end
                    end
                end
            end
            PUSH: begin
                raw_fifo_push = ~raw_fifo_full;
                if (!raw_fifo_full) begin
                    next_state = COLLECT_0;
                end
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    // Word assembly: lane 0 starts a fresh word (upper lanes zeroed), later lanes fill in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_data_out  <= '0;
            raw_index_out <= '0;
            raw_wstrb_out <= '0;
        end else if (latch_first) begin
            raw_data_out  <= {{(3*LANE_W){1'b0}}, enc_data_in};
            raw_index_out <= enc_index_in;
            raw_wstrb_out <= enc_wstrb_in;
        end else if (latch_next) begin
            for (int k = 1; k < 4; k++) begin
                if (cur_lane == 2'(k)) begin
                    raw_data_out[k*LANE_W +: LANE_W] <= enc_data_in;
                end
            end
        end
    end

    // Error pulse, saturating error counter, and the one-shot clear after leaving INIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_err     <= 1'b0;
            err_count    <= '0;
            raw_fifo_clr <= 1'b0;
        end else begin
            lane_err     <= seq_err;
            raw_fifo_clr <= (state == INIT);
            if (seq_err && err_count != '1) begin
                err_count <= err_count + ERR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_raw_data_decoder.sv
// Bench for raw_data_decoder: a queue models the encoded FIFO, a scoreboard queue
// holds the raw words expected on each push, and lane_err / clr pulses are tallied.
module tb_raw_data_decoder;

    typedef struct packed {
        logic [1:0] lane;
        logic [7:0] idx;
        logic [7:0] data;
        logic [3:0] wstrb;
    } lane_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  idx;
        logic [3:0]  wstrb;
    } word_t;

    typedef struct {
        logic [7:0]  idx;
        logic [3:0]  wstrb;
        logic [7:0]  l0, l1, l2, l3;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enc_fifo_empty;
    logic        enc_fifo_pop;
    logic [7:0]  enc_data_in;
    logic [1:0]  enc_lane_in;
    logic [7:0]  enc_index_in;
    logic [3:0]  enc_wstrb_in;
    logic        raw_fifo_full;
    logic        raw_fifo_push;
    logic        raw_fifo_clr;
    logic [31:0] raw_data_out;
    logic [7:0]  raw_index_out;
    logic [3:0]  raw_wstrb_out;
    logic        lane_err;
    logic [7:0]  err_count;

    lane_t enc_q[$];
    word_t sb[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    err_pulses = 0;
    int    clr_pulses = 0;
    logic  pop_seen;

    raw_data_decoder dut (
        .clk(clk), .reset_n(reset_n),
        .enc_fifo_empty(enc_fifo_empty), .enc_fifo_pop(enc_fifo_pop),
        .enc_data_in(enc_data_in), .enc_lane_in(enc_lane_in),
        .enc_index_in(enc_index_in), .enc_wstrb_in(enc_wstrb_in),
        .raw_fifo_full(raw_fifo_full), .raw_fifo_push(raw_fifo_push),
        .raw_fifo_clr(raw_fifo_clr), .raw_data_out(raw_data_out),
        .raw_index_out(raw_index_out), .raw_wstrb_out(raw_wstrb_out),
        .lane_err(lane_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive_head();
        if (enc_q.size() > 0) begin
            enc_fifo_empty = 1'b0;
            enc_lane_in    = enc_q[0].lane;
            enc_index_in   = enc_q[0].idx;
            enc_data_in    = enc_q[0].data;
            enc_wstrb_in   = enc_q[0].wstrb;
        end else begin
            enc_fifo_empty = 1'b1;
            enc_lane_in    = 2'd0;
            enc_index_in   = 8'd0;
            enc_data_in    = 8'd0;
            enc_wstrb_in   = 4'd0;
        end
    endtask

    task automatic enqueue_lane(input logic [1:0] lane, input logic [7:0] idx,
                                input logic [7:0] data, input logic [3:0] wstrb);
        enc_q.push_back('{lane: lane, idx: idx, data: data, wstrb: wstrb});
        drive_head();
    endtask

    // Enqueue a clean four-lane word and record the raw word it should produce.
    task automatic apply_stimulus(input vec_t v);
        enqueue_lane(2'd0, v.idx, v.l0, v.wstrb);
        enqueue_lane(2'd1, v.idx, v.l1, 4'd0);
        enqueue_lane(2'd2, v.idx, v.l2, 4'd0);
        enqueue_lane(2'd3, v.idx, v.l3, 4'd0);
        sb.push_back('{data: v.exp_data, idx: v.idx, wstrb: v.wstrb});
    endtask

    // One clock: monitor outputs on the falling edge, then retire a popped head.
    task automatic tick();
        word_t exp_w;
        @(negedge clk);
        if (lane_err)     err_pulses++;
        if (raw_fifo_clr) clr_pulses++;
        if (raw_fifo_push) begin
            if (raw_fifo_full) check_output("push_while_full", 1, 0);
            if (sb.size() == 0) begin
                check_output("unexpected_push", 1, 0);
            end else begin
                exp_w = sb.pop_front();
                check_output("raw_word", {raw_data_out, raw_index_out, raw_wstrb_out}, exp_w);
            end
        end
        pop_seen = enc_fifo_pop;
        @(posedge clk);
        #1;
        if (pop_seen && enc_q.size() > 0) void'(enc_q.pop_front());
        drive_head();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((enc_q.size() > 0 || sb.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check_output("drain", 64'(enc_q.size() + sb.size()), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_data"}, {raw_data_out, raw_index_out, raw_wstrb_out}, 0);
        check_output({tag, "_err"}, {lane_err, err_count}, 0);
        check_output({tag, "_handshake"}, {enc_fifo_pop, raw_fifo_push}, 0);
    endtask

    initial begin
        vec_t vecs[3];
        vec_t v;
        int   e0;
        vecs[0] = '{idx: 8'h05, wstrb: 4'hF, l0: 8'h11, l1: 8'h22, l2: 8'h33, l3: 8'h44,
                    exp_data: 32'h44332211};
        vecs[1] = '{idx: 8'h80, wstrb: 4'h1, l0: 8'h00, l1: 8'hFF, l2: 8'h00, l3: 8'hFF,
                    exp_data: 32'hFF00FF00};
        vecs[2] = '{idx: 8'hFF, wstrb: 4'hA, l0: 8'hDE, l1: 8'hAD, l2: 8'hBE, l3: 8'hEF,
                    exp_data: 32'hEFBEADDE};

        reset_n       = 1'b0;
        raw_fifo_full = 1'b0;
        drive_head();

        // Reset and release: one clr pulse, idle with empty FIFO.
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_clr", raw_fifo_clr, 0);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (5) tick();
        check_output("clr_pulse_count", clr_pulses, 1);
        check_idle_outputs("post_reset");

        // Clean words, back to back.
        for (int i = 0; i < 3; i++) apply_stimulus(vecs[i]);
        run_until_idle(100);
        check_output("no_err_clean", err_pulses, 0);

        // Back-pressure: word held in PUSH while full, next word stays in the FIFO.
        raw_fifo_full = 1'b1;
        apply_stimulus(vecs[0]);
        v = '{idx: 8'h06, wstrb: 4'h5, l0: 8'h88, l1: 8'h77, l2: 8'h66, l3: 8'h55,
              exp_data: 32'h55667788};
        apply_stimulus(v);
        repeat (10) tick();
        check_output("full_no_pop", enc_q.size(), 4);
        check_output("full_sb_pending", sb.size(), 2);
        check_output("full_hold", {raw_data_out, raw_index_out, raw_wstrb_out},
                     {32'h44332211, 8'h05, 4'hF});
        raw_fifo_full = 1'b0;
        run_until_idle(100);

        // Skipped lane 2: one error, then a clean word.
        e0 = err_pulses;
        enqueue_lane(2'd0, 8'h07, 8'hA0, 4'hF);
        enqueue_lane(2'd1, 8'h07, 8'hA1, 4'h0);
        enqueue_lane(2'd3, 8'h07, 8'hA3, 4'h0);
        v = '{idx: 8'h08, wstrb: 4'h3, l0: 8'hB0, l1: 8'hB1, l2: 8'hB2, l3: 8'hB3,
              exp_data: 32'hB3B2B1B0};
        apply_stimulus(v);
        run_until_idle(100);
        check_output("skip_err_pulses", err_pulses - e0, 1);
        check_output("skip_err_count", err_count, 1);

        // Early lane 0 with a new index restarts the word.
        e0 = err_pulses;
        enqueue_lane(2'd0, 8'h09, 8'hC0, 4'h1);
        enqueue_lane(2'd1, 8'h09, 8'hC1, 4'h0);
        v = '{idx: 8'h0A, wstrb: 4'h6, l0: 8'hD0, l1: 8'hD1, l2: 8'hD2, l3: 8'hD3,
              exp_data: 32'hD3D2D1D0};
        apply_stimulus(v);
        run_until_idle(100);
        check_output("restart_err_pulses", err_pulses - e0, 1);
        check_output("restart_err_count", err_count, 2);

        // Reset after lane 2: partial word dropped, counter cleared, clr again.
        enqueue_lane(2'd0, 8'h0C, 8'hE0, 4'hF);
        enqueue_lane(2'd1, 8'h0C, 8'hE1, 4'h0);
        enqueue_lane(2'd2, 8'h0C, 8'hE2, 4'h0);
        run_until_idle(50);
        reset_n = 1'b0;
        #2;
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset_n    = 1'b1;
        clr_pulses = 0;
        v = '{idx: 8'h0D, wstrb: 4'h9, l0: 8'h01, l1: 8'h02, l2: 8'h03, l3: 8'h04,
              exp_data: 32'h04030201};
        apply_stimulus(v);
        run_until_idle(100);
        check_output("rst_clr_pulse", clr_pulses, 1);
        check_output("rst_err_count", err_count, 0);

        // Saturation: every pulse still fires, counter stops at all-ones.
        e0 = err_pulses;
        for (int i = 0; i < 260; i++) enqueue_lane(2'd1, 8'h00, 8'(i), 4'h0);
        run_until_idle(400);
        check_output("sat_pulses", err_pulses - e0, 260);
        check_output("sat_count", err_count, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
